axis_axi_burst_writer: RTL
==========================

Name: axis_axi_burst_writer

Overview:
Write-side DMA master that sits directly upstream of the AXI4 RAM write channel. It takes a start command (base byte address, word count) and a valid/ready word stream, and issues INCR AXI4 write bursts to the RAM. Bursts are split at MAX_BURST beats and never cross a 4 KB boundary. AXI ID, lock, cache, prot and qos are not driven by this block; the integration level ties them to 0.

Parameters:
DATA_W, 32, data width; DATA_W/8 must be a power of two (STRB = DATA_W/8)
ADDR_W, 16, AXI byte address width
LEN_W, 8, AXI awlen width
MAX_BURST, 16, maximum beats per burst; 1..2**LEN_W
CNT_W, 16, width of word count

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  command strobe; sampled only in IDLE
base_addr_i  in  ADDR_W  start byte address; must be STRB-aligned
word_cnt_i  in  CNT_W  number of DATA_W words to write
busy_o  out  1  high while a command is in progress
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky: some bresp != OKAY since last start
s_tdata_i  in  DATA_W  stream data
s_tvalid_i  in  1  stream valid
s_tready_o  out  1  stream ready
axi_awaddr_o  out  ADDR_W  burst start address
axi_awlen_o  out  LEN_W  beats-1
axi_awsize_o  out  3  constant log2(STRB)
axi_awburst_o  out  2  constant 2'b01 (INCR)
axi_awvalid_o  out  1  address valid
axi_awready_i  in  1  address ready
axi_wdata_o  out  DATA_W  write data
axi_wstrb_o  out  STRB  constant all ones
axi_wlast_o  out  1  last beat of burst
axi_wvalid_o  out  1  write valid
axi_wready_i  in  1  write ready
axi_bresp_i  in  2  write response
axi_bvalid_i  in  1  response valid
axi_bready_o  out  1  response ready

Behaviour:
- Reset, or rst_i asserted in any state:
  - State goes to IDLE on the next edge; any in-flight burst is abandoned (the slave must be reset alongside).
  - Next cycle: awvalid, wvalid, wlast, bready, s_tready, busy, done, err = 0; awaddr = 0; awlen = 0.
- Registered state: state, cur_addr (ADDR_W), remaining (CNT_W), beat_cnt (LEN_W), cur_beats.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - busy_o = 0.
  - On start_i: latch cur_addr = base_addr_i and remaining = word_cnt_i; clear err_o.
  - If word_cnt_i == 0: done_o pulses on the next cycle and the FSM stays in IDLE.
  - Otherwise go to ADDR. awvalid_o is high on the cycle after start (latency 1).
- ADDR:
  - beats = min(remaining, MAX_BURST, (4096 - cur_addr[11:0]) / STRB). The 4 KB term is dropped if ADDR_W < 12.
  - awaddr_o = cur_addr; awlen_o = beats - 1.
  - awvalid_o stays high and awaddr/awlen stay stable until awready_i.
  - On handshake: beat_cnt = beats - 1; go to DATA.
  - No W beat is presented before its AW is accepted.
- DATA:
  - wvalid_o = s_tvalid_i; wdata_o = s_tdata_i; s_tready_o = axi_wready_i. This is a combinational pass-through, and wvalid never depends on wready.
  - wlast_o = (beat_cnt == 0).
  - Each wvalid && wready decrements beat_cnt.
  - On the last beat: cur_addr += beats*STRB (modulo 2**ADDR_W); remaining -= beats; go to RESP.
  - s_tready_o = 0 in all other states.
- RESP:
  - bready_o = 1.
  - On bvalid_i: err_o |= (bresp_i != 0).
  - If remaining == 0: done_o pulses for 1 cycle on the next cycle and the FSM goes to IDLE. Otherwise go to ADDR.
  - An error does not abort the transfer.
- busy_o = 1 in ADDR, DATA and RESP. start_i is ignored while busy.
- Only one burst is outstanding at a time.

Test Plan:
1. DATA_W=32, base 0x100, cnt 5:
   - One AW: addr 0x100, len 4, size 2, burst 01.
   - 5 W beats, wlast on beat 5 only.
   - done_o pulses 1 cycle after the B handshake; RAM words 0x100..0x110 match the stream.
2. base 0x0, cnt 40, MAX_BURST 16:
   - AWs: (0x000, len 15), (0x040, len 15), (0x080, len 7).
   - All 40 words land in order; a single done pulse.
3. base 0xFF8, cnt 6:
   - AWs: (0xFF8, len 1) then (0x1000, len 3); no burst crosses 0x1000.
4. Backpressure: random s_tvalid gaps, awready delayed 3 cycles, wready toggling, bvalid delayed 5 cycles:
   - awaddr/awlen stable while waiting for awready.
   - Data order preserved; no beat lost or duplicated.
5. cnt 0:
   - done_o pulses the cycle after start; no AW issued; busy_o stays 0.
   - A second start_i during a cnt-8 transfer is ignored (exactly 8 beats written).
6. Error and reset:
   - bresp = 2'b10 on the 2nd of 3 bursts: err_o = 1 from that B onward, the 3rd burst still issues, done pulses; err_o clears on the next start_i.
   - rst_i high mid-DATA: the next cycle all outputs are 0 and busy_o = 0.

Source files
------------

// File: rtl/axis_axi_burst_writer.sv
// Write-side DMA master: turns a (base, word count) command plus a word stream into INCR AXI4
// write bursts, split at MAX_BURST beats and at 4 KB page boundaries, one burst in flight.
module axis_axi_burst_writer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [CNT_W-1:0]      word_cnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,

    input  logic [DATA_W-1:0]     s_tdata_i,
    input  logic                  s_tvalid_i,
    output logic                  s_tready_o,

    output logic [ADDR_W-1:0]     axi_awaddr_o,
    output logic [LEN_W-1:0]      axi_awlen_o,
    output logic [2:0]            axi_awsize_o,
    output logic [1:0]            axi_awburst_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,

    output logic [DATA_W-1:0]     axi_wdata_o,
    output logic [DATA_W/8-1:0]   axi_wstrb_o,
    output logic                  axi_wlast_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,

    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o
);

    localparam int unsigned STRB     = DATA_W / 8;
    localparam int unsigned StrbLog2 = $clog2(STRB);
    localparam int unsigned BeatsW   = LEN_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BeatsW-1:0]   cur_beats_q, cur_beats_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [31:0]         rem_beats;
    logic [31:0]         page_beats;
    logic [31:0]         burst_beats;
    logic                w_hs;

    // Beats left before the next 4 KB page; unbounded when the address space is smaller.
    if (ADDR_W >= 12) begin : g_page
        assign page_beats = (32'd4096 - 32'(cur_addr_q[11:0])) >> StrbLog2;
    end else begin : g_no_page
        assign page_beats = '1;
    end

    assign rem_beats = 32'(remaining_q);

    always_comb begin
        burst_beats = rem_beats;
        if (32'(MAX_BURST) < burst_beats) begin
            burst_beats = 32'(MAX_BURST);
        end
        if (page_beats < burst_beats) begin
            burst_beats = page_beats;
        end
    end

    assign w_hs = (state_q == StData) && s_tvalid_i && axi_wready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            cur_beats_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            cur_beats_q <= cur_beats_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        cur_beats_d = cur_beats_q;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cur_addr_d  = base_addr_i;
                    remaining_d = word_cnt_i;
                    err_d       = 1'b0;
                    if (word_cnt_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (axi_awready_i) begin
                    beat_cnt_d  = LEN_W'(burst_beats - 32'd1);
                    cur_beats_d = BeatsW'(burst_beats);
                    state_d     = StData;
                end
            end
            StData: begin
                if (w_hs) begin
                    if (beat_cnt_q == '0) begin
                        cur_addr_d  = cur_addr_q + ADDR_W'(32'(cur_beats_q) << StrbLog2);
                        remaining_d = remaining_q - CNT_W'(cur_beats_q);
                        state_d     = StResp;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            StResp: begin
                if (axi_bvalid_i) begin
                    if (axi_bresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    // An error response is recorded but the transfer carries on.
                    if (remaining_q == '0) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        axi_awvalid_o = 1'b0;
        axi_awaddr_o  = '0;
        axi_awlen_o   = '0;
        axi_wvalid_o  = 1'b0;
        axi_wdata_o   = '0;
        axi_wlast_o   = 1'b0;
        s_tready_o    = 1'b0;
        axi_bready_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StAddr: begin
                axi_awvalid_o = 1'b1;
                axi_awaddr_o  = cur_addr_q;
                axi_awlen_o   = LEN_W'(burst_beats - 32'd1);
            end
            StData: begin
                // Stream passes straight through; wvalid never waits on wready.
                axi_wvalid_o = s_tvalid_i;
                axi_wdata_o  = s_tdata_i;
                axi_wlast_o  = (beat_cnt_q == '0);
                s_tready_o   = axi_wready_i;
            end
            StResp: begin
                axi_bready_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign axi_awsize_o  = 3'(StrbLog2);
    assign axi_awburst_o = 2'b01;
    assign axi_wstrb_o   = '1;

endmodule
